// File: rtl/ps2_kbmatrix_if.sv
// PS/2 keyboard-to-Z88-matrix bus: raw PS/2 lines in, key matrix and event
// pulses out. The design uses the slave modport; the keyboard side (or a
// bench) uses master.
interface ps2_kbmatrix_if;
   logic        ps2_clk;
   logic        ps2_dat;
   logic [63:0] kbmatrix;
   logic        key_evt;
   logic        rx_err;

   modport master (
      output ps2_clk,
      output ps2_dat,
      input  kbmatrix,
      input  key_evt,
      input  rx_err
   );

   modport slave (
      input  ps2_clk,
      input  ps2_dat,
      output kbmatrix,
      output key_evt,
      output rx_err
   );
endinterface

// File: rtl/ps2_kbmatrix.sv
// PS/2 keyboard receiver and scan-code decoder driving a Z88 key matrix
// (bit = row*8+col, 0 = pressed).
// Optional macro PS2_RX_TIMEOUT_EN adds an inter-fall receive timeout.
//
// Decoder FSM
//    state      | meaning
//    ST_IDLE    | waiting for a code or prefix
//    ST_BRK     | F0 seen, next code is a release
//    ST_EXT     | E0 seen, next code is an extended press
//    ST_EXT_BRK | E0 F0 seen, next code is an extended release
module ps2_kbmatrix #(
   parameter int unsigned CLK_HZ     = 25_000_000,
   parameter int unsigned TIMEOUT_US = 2000
) (
   input logic            clk,
   input logic            reset_n,
   ps2_kbmatrix_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } state_e;

   // Returns {valid, matrix index}. Ctrl (14) and 77 are left unmapped so
   // the E1 Pause sequence has no effect on the matrix.
   function automatic logic [6:0] key_map(input logic ext, input logic [7:0] code);
      logic [6:0] m;
      m = 7'd0;
      case ({ext, code})
         9'h0_5A: m = {1'b1, 6'd6};    // Enter
         9'h0_66: m = {1'b1, 6'd7};    // Delete
         9'h0_75: m = {1'b1, 6'd21};   // keypad 8
         9'h0_16: m = {1'b1, 6'd33};   // 1
         9'h0_1E: m = {1'b1, 6'd34};   // 2
         9'h0_26: m = {1'b1, 6'd35};   // 3
         9'h0_25: m = {1'b1, 6'd36};   // 4
         9'h0_15: m = {1'b1, 6'd41};   // Q
         9'h0_1D: m = {1'b1, 6'd42};   // W
         9'h0_24: m = {1'b1, 6'd43};   // E
         9'h0_2D: m = {1'b1, 6'd44};   // R
         9'h0_29: m = {1'b1, 6'd46};   // Space
         9'h0_1C: m = {1'b1, 6'd49};   // A
         9'h0_1B: m = {1'b1, 6'd50};   // S
         9'h0_23: m = {1'b1, 6'd51};   // D
         9'h0_2B: m = {1'b1, 6'd52};   // F
         9'h0_34: m = {1'b1, 6'd53};   // G
         9'h0_12: m = {1'b1, 6'd54};   // Left shift
         9'h0_1A: m = {1'b1, 6'd57};   // Z
         9'h0_22: m = {1'b1, 6'd58};   // X
         9'h0_21: m = {1'b1, 6'd59};   // C
         9'h0_0D: m = {1'b1, 6'd60};   // Tab
         9'h0_76: m = {1'b1, 6'd61};   // Esc
         9'h0_2A: m = {1'b1, 6'd62};   // V
         9'h0_59: m = {1'b1, 6'd63};   // Right shift
         9'h1_6B: m = {1'b1, 6'd11};   // Left arrow
         9'h1_74: m = {1'b1, 6'd12};   // Right arrow
         9'h1_72: m = {1'b1, 6'd13};   // Down arrow
         9'h1_75: m = {1'b1, 6'd14};   // Up arrow
         default: m = 7'd0;
      endcase
      return m;
   endfunction

   logic [1:0]  clk_sync_q;
   logic [1:0]  dat_sync_q;
   logic        clk_prev_q;
   logic        fall_w;
   logic        dat_w;

   logic        busy_q;
   logic [3:0]  cnt_q;
   logic [7:0]  shift_q;
   logic        par_q;
   logic [7:0]  byte_q;
   logic        byte_vld_q;
   logic        rx_err_q;
   logic        frame_ok_w;
   logic        timeout_w;

   state_e      state_q, state_d;
   logic [63:0] kbmatrix_q, kbmatrix_d;
   logic        key_evt_q, key_evt_d;
   logic        ext_w;
   logic        brk_w;
   logic [6:0]  map_w;

   // Two-flop synchronisers and previous-clock register for fall detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
         dat_sync_q <= {dat_sync_q[0], bus.ps2_dat};
         clk_prev_q <= clk_sync_q[1];
      end
   end

   assign fall_w     = clk_prev_q & ~clk_sync_q[1];
   assign dat_w      = dat_sync_q[1];
   // Stop bit high and odd parity over data plus parity bit
   assign frame_ok_w = dat_w & (^{shift_q, par_q});

`ifdef PS2_RX_TIMEOUT_EN
   localparam logic [31:0] TO_LOAD = 32'((CLK_HZ / 1_000_000) * TIMEOUT_US);

   logic [31:0] tmo_q;

   // Inter-fall watchdog: reloads on every fall, runs down only mid-frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q <= 32'd0;
      end else if (fall_w) begin
         tmo_q <= TO_LOAD;
      end else if (busy_q && (tmo_q != 32'd0)) begin
         tmo_q <= tmo_q - 32'd1;
      end
   end

   assign timeout_w = busy_q & ~fall_w & (tmo_q == 32'd0);
`else
   assign timeout_w = 1'b0;
`endif

   // Frame receiver: start, 8 data LSB first, parity, stop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q     <= 1'b0;
         cnt_q      <= 4'd0;
         shift_q    <= 8'd0;
         par_q      <= 1'b0;
         byte_q     <= 8'd0;
         byte_vld_q <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         byte_vld_q <= 1'b0;
         rx_err_q   <= 1'b0;
         if (fall_w) begin
            if (!busy_q) begin
               // A high start bit is treated as a line glitch
               if (!dat_w) begin
                  busy_q <= 1'b1;
                  cnt_q  <= 4'd1;
               end
            end else if (cnt_q <= 4'd8) begin
               shift_q <= {dat_w, shift_q[7:1]};
               cnt_q   <= cnt_q + 4'd1;
            end else if (cnt_q == 4'd9) begin
               par_q <= dat_w;
               cnt_q <= 4'd10;
            end else begin
               busy_q     <= 1'b0;
               cnt_q      <= 4'd0;
               byte_q     <= shift_q;
               byte_vld_q <= frame_ok_w;
               rx_err_q   <= ~frame_ok_w;
            end
         end else if (timeout_w) begin
            busy_q   <= 1'b0;
            cnt_q    <= 4'd0;
            rx_err_q <= 1'b1;
         end
      end
   end

   assign ext_w = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
   assign brk_w = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
   assign map_w = key_map(ext_w, byte_q);

   // Decoder state, matrix and event registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         kbmatrix_q <= '1;
         key_evt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         kbmatrix_q <= kbmatrix_d;
         key_evt_q  <= key_evt_d;
      end
   end

   // Decoder next state and matrix update on each received byte
   always_comb begin
      state_d    = state_q;
      kbmatrix_d = kbmatrix_q;
      if (byte_vld_q) begin
         if ((byte_q == 8'hAA) || (byte_q == 8'hFC)) begin
            // Keyboard self-test finished: nothing can be held
            kbmatrix_d = '1;
            state_d    = ST_IDLE;
         end else if ((state_q == ST_IDLE) && (byte_q == 8'hE0)) begin
            state_d = ST_EXT;
         end else if ((state_q == ST_IDLE) && (byte_q == 8'hF0)) begin
            state_d = ST_BRK;
         end else if ((state_q == ST_EXT) && (byte_q == 8'hF0)) begin
            state_d = ST_EXT_BRK;
         end else begin
            if (map_w[6]) begin
               kbmatrix_d[map_w[5:0]] = brk_w;
            end
            state_d = ST_IDLE;
         end
      end
      // Typematic repeats rewrite the same value and so raise no event
      key_evt_d = (kbmatrix_d != kbmatrix_q);
   end

   assign bus.kbmatrix = kbmatrix_q;
   assign bus.key_evt  = key_evt_q;
   assign bus.rx_err   = rx_err_q;

endmodule

// File: doc/ps2_kbmatrix.md
PS2_KBMATRIX -- requirements
Module: ps2_kbmatrix

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 2000, allowed gap in microseconds between PS/2 clock falls within one frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n  input  1  reset: asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-006 SHALL have port ps2_dat  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port kbmatrix  output  64  Z88 key matrix; bit index = row*8+col; 0 = pressed.
REQ-008 SHALL have port key_evt  output  1  one-cycle pulse when a kbmatrix bit changes.
REQ-009 SHALL have port rx_err  output  1  one-cycle pulse on a framing, parity or timeout error.

Function
REQ-010 SHALL synchronise ps2_clk and ps2_dat through two flip-flops each and detect a falling edge of the synchronised clock.
REQ-011 SHALL sample data on each detected fall: start(0), 8 data bits LSB first, odd parity, stop(1); 11 falls per frame.
REQ-012 SHALL treat start=1 on the first fall as a glitch and stay idle, with no rx_err.
REQ-013 SHALL discard the byte and pulse rx_err one cycle after the 11th fall on a parity mismatch or stop=0.
REQ-014 SHALL present a valid byte to the decoder one cycle after the 11th fall.
REQ-015 SHALL run a decoder FSM with states IDLE, BRK (after F0), EXT (after E0) and EXT_BRK (E0 then F0).
REQ-016 SHALL move IDLE->EXT on E0, IDLE->BRK on F0, EXT->EXT_BRK on F0, and any other byte -> IDLE after acting on it.
REQ-017 SHALL make a make code clear the mapped bit and a break code set it, two cycles after the 11th fall.
REQ-018 SHALL pulse key_evt only when the mapped bit actually changes value; typematic repeats of a held key SHALL NOT pulse.
REQ-019 SHALL ignore unmapped codes, including E1 sequences, and return to IDLE with no matrix change.
REQ-020 SHALL set all 64 bits to 1 on byte AA (BAT complete) or FC (BAT fail), in any FSM state, and go to IDLE.
REQ-021 SHALL use a fixed combinational key map with these required entries: 1C->49, 5A->6, 12->54, 59->63, E0 75->14, E0 6B->11; remaining entries SHALL follow the team Z88 key-map table.
REQ-022 SHALL give prefix bytes no visible effect besides the FSM state change.

Reset
REQ-023 SHALL, while reset_n=0, drive kbmatrix=all 1s and key_evt=rx_err=0, clear the receiver to idle, set the FSM to IDLE and clear the synchronisers to 1.
REQ-024 SHALL, if reset is asserted mid-frame, discard the partial frame; the next start bit begins a fresh frame.

Configuration
REQ-025 SHALL compile a receive timeout when macro PS2_RX_TIMEOUT_EN is defined: a counter reloads to CLK_HZ/1000000*TIMEOUT_US on every fall.
REQ-026 SHALL, with PS2_RX_TIMEOUT_EN, abandon a frame whose counter reaches 0 mid-frame, return the receiver to idle and pulse rx_err once.
REQ-027 SHALL, without PS2_RX_TIMEOUT_EN, omit the counter and leave a partial frame pending indefinitely, with no timeout rx_err.

Verification
REQ-028 SHALL cover: frame 1C then F0 1C -> bit 49 goes 0 then 1, two key_evt pulses, all other bits 1.
REQ-029 SHALL cover: E0 75 then E0 F0 75 -> bit 14 goes 0 then 1; bit 21 (unextended 75) never changes.
REQ-030 SHALL cover: byte 5A with even parity -> rx_err pulse, bit 6 stays 1, FSM stays IDLE.
REQ-031 SHALL cover: 12 make sent three times -> bit 54 = 0 with exactly one key_evt.
REQ-032 SHALL cover: 5 clock falls then a 3 ms idle gap with PS2_RX_TIMEOUT_EN and CLK_HZ=25 MHz -> one rx_err, and a following valid 5A frame is decoded to bit 6 = 0.
REQ-033 SHALL cover: keys 49 and 6 held, then byte AA -> kbmatrix = FFFF_FFFF_FFFF_FFFF; reset_n pulsed mid-frame -> all 1s and a clean next frame.
